// File: rtl/booth_mul_seq_if.sv
// Bus bundle between the Booth multiplier command sequencer, its requester,
// its result consumer and the multiplier core's din/addr/ctrl/Partial_Product port.
interface booth_mul_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] mul_din;
  logic [15:0] mul_addr;
  logic [2:0]  mul_ctrl;
  logic [31:0] mul_pp;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] result;
  logic [15:0] op_count;

  // Sequencer side
  modport slave (
    input  req_valid, op_a, op_b, mul_pp, res_ready,
    output req_ready, mul_din, mul_addr, mul_ctrl, res_valid, result, op_count
  );

  // Requester / consumer / core side
  modport master (
    output req_valid, op_a, op_b, mul_pp, res_ready,
    input  req_ready, mul_din, mul_addr, mul_ctrl, res_valid, result, op_count
  );
endinterface

// File: rtl/booth_mul_seq.sv
// Command sequencer for the 32-bit Booth multiplier core: loads both operands,
// pulses start, waits out the iteration count, reads back the low and high
// product halves and presents the 64-bit {hi,lo} result over valid/ready.
module booth_mul_seq #(
  parameter int          MUL_CYCLES = 34,
  parameter logic [15:0] ADDR_A     = 16'h0000,
  parameter logic [15:0] ADDR_B     = 16'h0004,
  parameter logic [15:0] ADDR_IDLE  = 16'hFF00
) (
  input  logic CLK,
  input  logic RST,
  booth_mul_seq_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LOAD_A = 4'd1,
    S_LOAD_B = 4'd2,
    S_START  = 4'd3,
    S_WAIT   = 4'd4,
    S_RD_LO  = 4'd5,
    S_CAP_LO = 4'd6,
    S_RD_HI  = 4'd7,
    S_CAP_HI = 4'd8,
    S_DONE   = 4'd9
  } state_t;

  localparam logic [15:0] WAIT_LAST = 16'(MUL_CYCLES - 1);

  state_t      state_r;
  state_t      state_nxt_s;
  logic [31:0] op_a_r;
  logic [31:0] op_b_r;
  logic [15:0] wait_cnt_r;
  logic        wait_last_s;
  logic [63:0] result_r;
  logic [15:0] op_count_r;

  logic        req_ready_r;
  logic        res_valid_r;
  logic [31:0] mul_din_r;
  logic [15:0] mul_addr_r;
  logic [2:0]  mul_ctrl_r;

  logic        req_ready_nxt_s;
  logic        res_valid_nxt_s;
  logic [31:0] mul_din_nxt_s;
  logic [15:0] mul_addr_nxt_s;
  logic [2:0]  mul_ctrl_nxt_s;

  assign wait_last_s = (wait_cnt_r == WAIT_LAST);

  // State register; reset aborts any in-flight transaction
  always_ff @(posedge CLK) begin
    if (!RST) state_r <= S_IDLE;
    else      state_r <= state_nxt_s;
  end

  // Next-state decode; unknown encodings fall back to IDLE
  always_comb begin
    state_nxt_s = S_IDLE;
    case (state_r)
      S_IDLE: begin
        if (bus.req_valid) state_nxt_s = S_LOAD_A;
        else               state_nxt_s = S_IDLE;
      end
      S_LOAD_A: state_nxt_s = S_LOAD_B;
      S_LOAD_B: state_nxt_s = S_START;
      S_START:  state_nxt_s = S_WAIT;
      S_WAIT: begin
        if (wait_last_s) state_nxt_s = S_RD_LO;
        else             state_nxt_s = S_WAIT;
      end
      S_RD_LO:  state_nxt_s = S_CAP_LO;
      S_CAP_LO: state_nxt_s = S_RD_HI;
      S_RD_HI:  state_nxt_s = S_CAP_HI;
      S_CAP_HI: state_nxt_s = S_DONE;
      S_DONE: begin
        if (bus.res_ready) state_nxt_s = S_IDLE;
        else               state_nxt_s = S_DONE;
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Output decode of the upcoming state, so the registered outputs track the
  // state register exactly (LOAD_A is only entered on an accept, where the
  // operand being captured is the live op_a)
  always_comb begin
    req_ready_nxt_s = 1'b0;
    res_valid_nxt_s = 1'b0;
    mul_din_nxt_s   = 32'h0000_0000;
    mul_addr_nxt_s  = ADDR_IDLE;
    mul_ctrl_nxt_s  = 3'b000;
    case (state_nxt_s)
      S_IDLE:   req_ready_nxt_s = 1'b1;
      S_LOAD_A: begin
        mul_addr_nxt_s = ADDR_A;
        mul_din_nxt_s  = bus.op_a;
      end
      S_LOAD_B: begin
        mul_addr_nxt_s = ADDR_B;
        mul_din_nxt_s  = op_b_r;
      end
      S_START:  mul_ctrl_nxt_s  = 3'b001;
      S_RD_LO:  mul_ctrl_nxt_s  = 3'b100;
      S_RD_HI:  mul_ctrl_nxt_s  = 3'b010;
      S_DONE:   res_valid_nxt_s = 1'b1;
      default:  req_ready_nxt_s = 1'b0;
    endcase
  end

  // Output registers
  always_ff @(posedge CLK) begin
    if (!RST) begin
      req_ready_r <= 1'b1;
      res_valid_r <= 1'b0;
      mul_din_r   <= 32'h0000_0000;
      mul_addr_r  <= ADDR_IDLE;
      mul_ctrl_r  <= 3'b000;
    end else begin
      req_ready_r <= req_ready_nxt_s;
      res_valid_r <= res_valid_nxt_s;
      mul_din_r   <= mul_din_nxt_s;
      mul_addr_r  <= mul_addr_nxt_s;
      mul_ctrl_r  <= mul_ctrl_nxt_s;
    end
  end

  // Operand capture, wait counter and product assembly
  always_ff @(posedge CLK) begin
    if (!RST) begin
      op_a_r     <= 32'h0000_0000;
      op_b_r     <= 32'h0000_0000;
      wait_cnt_r <= 16'h0000;
      result_r   <= 64'h0;
    end else begin
      if (state_r == S_IDLE && bus.req_valid) begin
        op_a_r <= bus.op_a;
        op_b_r <= bus.op_b;
      end
      if (state_r == S_START)     wait_cnt_r <= 16'h0000;
      else if (state_r == S_WAIT) wait_cnt_r <= wait_cnt_r + 16'h0001;
      // Core Partial_Product answers one cycle after the read pulse
      if (state_r == S_CAP_LO)      result_r[31:0]  <= bus.mul_pp;
      else if (state_r == S_CAP_HI) result_r[63:32] <= bus.mul_pp;
    end
  end

  // Completed-transaction counter, wraps naturally at 16 bits
  always_ff @(posedge CLK) begin
    if (!RST)                     op_count_r <= 16'h0000;
    else if (state_r == S_CAP_HI) op_count_r <= op_count_r + 16'h0001;
  end

  assign bus.req_ready = req_ready_r;
  assign bus.res_valid = res_valid_r;
  assign bus.mul_din   = mul_din_r;
  assign bus.mul_addr  = mul_addr_r;
  assign bus.mul_ctrl  = mul_ctrl_r;
  assign bus.result    = result_r;
  assign bus.op_count  = op_count_r;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Scoreboard bench for booth_mul_seq with a behavioural multiplier core model.
module tb_booth_mul_seq;

  logic CLK;
  logic RST;
  booth_mul_seq_if bus();

  booth_mul_seq dut (.CLK(CLK), .RST(RST), .bus(bus));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [63:0] res;
    logic [15:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          acc_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          n_start = 0;
  int          n_lo = 0;
  int          n_hi = 0;
  int          last_hs_cyc = 0;
  bit          seen_valid = 1'b0;
  bit          prev_valid = 1'b0;
  logic [63:0] prev_result = 64'h0;
  logic [15:0] cnt_model = 16'h0000;

  always @(posedge CLK) cyc <= cyc + 1;

  // Behavioural core: operand writes, start computes, reads return with 1-cycle latency
  logic signed [31:0] core_a;
  logic signed [31:0] core_b;
  logic signed [63:0] core_p;
  always @(posedge CLK) begin
    if (bus.mul_addr == 16'h0000) core_a <= bus.mul_din;
    if (bus.mul_addr == 16'h0004) core_b <= bus.mul_din;
    if (bus.mul_ctrl[0]) core_p <= core_a * core_b;
    if (bus.mul_ctrl[2])      bus.mul_pp <= core_p[31:0];
    else if (bus.mul_ctrl[1]) bus.mul_pp <= core_p[63:32];
    else                      bus.mul_pp <= 32'hDEAD_BEEF;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s", nm);
  endtask

  // Monitor: pulse counting, latency, stability and scoreboard pop on handshake
  always @(negedge CLK) begin
    if (RST) begin
      if (bus.mul_ctrl[0]) n_start++;
      if (bus.mul_ctrl[1]) n_hi++;
      if (bus.mul_ctrl[2]) n_lo++;
      if (bus.res_valid) begin
        seen_valid = 1'b1;
        chk("req_ready_in_done", {63'h0, bus.req_ready}, 64'h0);
        if (!prev_valid) begin
          if (acc_q.size() > 0) chk("latency", 64'(cyc - acc_q.pop_front()), 64'd41);
          else fail_now("unexpected_res_valid");
        end else begin
          chk("result_stable", bus.result, prev_result);
        end
        if (bus.res_ready) begin
          if (exp_q.size() == 0) begin
            fail_now("unexpected_result");
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("result", bus.result, e.res);
            chk("op_count", {48'h0, bus.op_count}, {48'h0, e.cnt});
          end
          chk("start_pulses", 64'(n_start), 64'd1);
          chk("rd_lo_pulses", 64'(n_lo), 64'd1);
          chk("rd_hi_pulses", 64'(n_hi), 64'd1);
          n_start = 0;
          n_lo = 0;
          n_hi = 0;
          last_hs_cyc = cyc + 1;
        end
      end
      prev_valid  = bus.res_valid;
      prev_result = bus.result;
    end else begin
      prev_valid = 1'b0;
    end
  end

  // Offer an operand pair, push the expected response on accept; called at a negedge
  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [63:0] exp, input bit hold, output int acc);
    int t;
    exp_t e;
    bus.op_a = a;
    bus.op_b = b;
    bus.req_valid = 1'b1;
    t = 0;
    while (!bus.req_ready && t < 300) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 300) fail_now("accept_timeout");
    @(posedge CLK);
    #1;
    acc = cyc;
    cnt_model = cnt_model + 16'h0001;
    e.res = exp;
    e.cnt = cnt_model;
    exp_q.push_back(e);
    acc_q.push_back(acc);
    @(negedge CLK);
    if (!hold) bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge CLK);
      t++;
    end
    if (exp_q.size() != 0) fail_now("result_timeout");
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_req_ready"}, {63'h0, bus.req_ready}, 64'h1);
    chk({nm, "_res_valid"}, {63'h0, bus.res_valid}, 64'h0);
    chk({nm, "_ctrl"}, {61'h0, bus.mul_ctrl}, 64'h0);
    chk({nm, "_addr"}, {48'h0, bus.mul_addr}, 64'hFF00);
  endtask

  initial begin
    int acc;
    int t;
    bus.req_valid = 1'b0;
    bus.res_ready = 1'b1;
    bus.op_a = 32'h0;
    bus.op_b = 32'h0;
    RST = 1'b0;

    // Reset then idle
    @(posedge CLK);
    @(negedge CLK);
    chk_idle("rst");
    chk("rst_op_count", {48'h0, bus.op_count}, 64'h0);
    chk("rst_result", bus.result, 64'h0);
    chk("rst_din", {32'h0, bus.mul_din}, 64'h0);
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk_idle("idle");
      chk("idle_op_count", {48'h0, bus.op_count}, 64'h0);
    end

    // Single op: 3 * -5
    send(32'd3, 32'hFFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0, acc);
    drain();

    // Backpressure: 0x7FFFFFFF * 2, requests offered while DONE must be ignored
    bus.res_ready = 1'b0;
    send(32'h7FFF_FFFF, 32'd2, 64'h0000_0000_FFFF_FFFE, 1'b0, acc);
    t = 0;
    while (!bus.res_valid && t < 100) begin
      @(negedge CLK);
      t++;
    end
    if (!bus.res_valid) fail_now("bp_valid_timeout");
    bus.op_a = 32'd9;
    bus.op_b = 32'd9;
    bus.req_valid = 1'b1;
    repeat (20) @(negedge CLK);
    bus.req_valid = 1'b0;
    bus.res_ready = 1'b1;
    @(negedge CLK);
    chk("bp_idle_req_ready", {63'h0, bus.req_ready}, 64'h1);
    chk("bp_idle_res_valid", {63'h0, bus.res_valid}, 64'h0);
    drain();

    // Back-to-back with req_valid held: 7*6 then -2*-3
    send(32'd7, 32'd6, 64'd42, 1'b1, acc);
    send(32'hFFFF_FFFE, 32'hFFFF_FFFD, 64'd6, 1'b0, acc);
    chk("b2b_accept_gap", 64'(acc - last_hs_cyc), 64'd1);
    drain();

    // Reset during WAIT cycle 10
    n_start = 0;
    n_lo = 0;
    n_hi = 0;
    seen_valid = 1'b0;
    bus.op_a = 32'd5;
    bus.op_b = 32'd5;
    bus.req_valid = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    bus.req_valid = 1'b0;
    repeat (12) @(negedge CLK);
    chk("abort_start_pulse", 64'(n_start), 64'd1);
    RST = 1'b0;
    @(negedge CLK);
    chk_idle("abort");
    RST = 1'b1;
    repeat (60) @(negedge CLK);
    chk("abort_rd_lo", 64'(n_lo), 64'd0);
    chk("abort_rd_hi", 64'(n_hi), 64'd0);
    chk("abort_no_valid", {63'h0, seen_valid}, 64'h0);
    chk("abort_op_count", {48'h0, bus.op_count}, 64'h0);
    n_start = 0;
    cnt_model = 16'h0000;

    // op_count wrap: preload then complete -1 * 1 and 0x80000000^2
    force dut.op_count_r = 16'hFFFF;
    @(negedge CLK);
    release dut.op_count_r;
    @(negedge CLK);
    chk("wrap_preload", {48'h0, bus.op_count}, 64'hFFFF);
    cnt_model = 16'hFFFF;
    send(32'hFFFF_FFFF, 32'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, acc);
    drain();
    chk("wrap_zero", {48'h0, bus.op_count}, 64'h0);
    send(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0, acc);
    drain();

    repeat (3) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/booth_mul_seq.md
Name: booth_mul_seq

Overview:
- Command sequencer directly upstream of the 32-bit Booth multiplier core; it is the only driver of the core's din/addr/ctrl bus.
- Accepts one operand pair per transaction over a valid/ready handshake.
- Loads operands into the core, issues the start pulse and waits out the fixed iteration count.
- Reads the low and high product halves back through the core's Partial_Product port and presents a 64-bit result over a valid/ready handshake.

Parameters:
- MUL_CYCLES, 34: cycles held in WAIT after the start pulse; covers the core's load cycle plus 32 iterations plus margin.
- ADDR_A, 16'h0000: core address for the multiplicand write.
- ADDR_B, 16'h0004: core address for the multiplier write.
- ADDR_IDLE, 16'hFF00: parked core address; addr[15:8] != 8'h00, so no operand load occurs.

Ports:
- CLK  in  1  clock; all logic on rising edge
- RST  in  1  synchronous active-low reset
- req_valid  in  1  operand pair offered
- req_ready  out  1  sequencer can accept an operand pair
- op_a  in  32  signed multiplicand
- op_b  in  32  signed multiplier
- mul_din  out  32  to core din
- mul_addr  out  16  to core addr
- mul_ctrl  out  3  to core ctrl; [0]=start/clear counter, [1]=read high half, [2]=read low half
- mul_pp  in  32  from core Partial_Product
- res_valid  out  1  result available
- res_ready  in  1  consumer takes result
- result  out  64  {high, low} signed product
- op_count  out  16  completed transactions, wraps at 16'hFFFF->0

Behaviour:
- Reset: RST sampled low at a rising edge sets the following:
  - state=IDLE, result=0, op_count=0, captured operands=0, wait counter=0
  - res_valid=0, mul_ctrl=3'b000, mul_addr=ADDR_IDLE, mul_din=0
- Reset mid-transaction: the sequencer aborts to IDLE on that edge. No further start or read pulses are issued. Any pending result is discarded and op_count is not incremented.
- mul_din, mul_addr, mul_ctrl are Moore decodes of the state register, constant within a state. States not listed below drive ADDR_IDLE, 0 and 3'b000.
- FSM (one state per cycle unless noted):
  - IDLE: req_ready=1. req_valid&&req_ready captures op_a/op_b and moves to LOAD_A. req_ready=0 in every other state.
  - LOAD_A: mul_addr=ADDR_A, mul_din=captured A, then LOAD_B.
  - LOAD_B: mul_addr=ADDR_B, mul_din=captured B, then START.
  - START: mul_ctrl=3'b001, wait counter cleared, then WAIT.
  - WAIT: counter increments each cycle. Leaves to RD_LO on the cycle the counter reaches MUL_CYCLES-1, so WAIT lasts exactly MUL_CYCLES cycles.
  - RD_LO: mul_ctrl=3'b100, then CAP_LO.
  - CAP_LO: result[31:0]<=mul_pp at the end of the cycle (core Partial_Product has 1-cycle read latency), then RD_HI.
  - RD_HI: mul_ctrl=3'b010, then CAP_HI.
  - CAP_HI: result[63:32]<=mul_pp, op_count<=op_count+1, then DONE.
  - DONE: res_valid=1. result is held stable until res_valid&&res_ready, then IDLE.
- Latency: from the accepting edge to res_valid high is MUL_CYCLES+7 edges (41 at default).
- Back-to-back: the earliest next accept is the cycle after the DONE handshake; there is no overlap with an in-flight operation.
- Backpressure: DONE is held indefinitely while res_ready=0. req_valid is ignored outside IDLE.
- Simultaneous events: req_valid arriving in the same cycle as the DONE handshake is not accepted; it is accepted on the next cycle in IDLE.
- Exactly one ctrl pulse is issued per START/RD_LO/RD_HI visit, and none during WAIT.
- result is the raw {hi,lo} concatenation; no sign correction is applied.
- Undefined state encodings return to IDLE.

Test Plan:
- Reset then idle:
  - Stimulus: RST low 2 cycles, then high, with req_valid=0.
  - Required: req_ready=1, res_valid=0, mul_ctrl=0, mul_addr=16'hFF00, op_count=0 throughout.
- Single op with core stub:
  - Stimulus: op_a=3, op_b=-5; stub returns 32'hFFFFFFF1 on low read and 32'hFFFFFFFF on high read.
  - Required: ADDR_A write of 3, ADDR_B write of 32'hFFFFFFFB, one start pulse, reads at WAIT+0 and WAIT+2, res_valid 41 edges after accept, result=64'hFFFFFFFF_FFFFFFF1, op_count=1.
- Backpressure:
  - Stimulus: hold res_ready=0 for 20 cycles after res_valid.
  - Required: result stable, no ctrl pulses, req_ready=0. res_ready=1 leads to IDLE next edge.
- Back-to-back with real core:
  - Stimulus: pairs (7,6) then (-2,-3), with req_valid held high.
  - Required: results 42 then 6, second accept exactly one cycle after first DONE handshake.
- Reset mid-operation:
  - Stimulus: pull RST low during WAIT cycle 10.
  - Required: IDLE on that edge, no RD_LO/RD_HI pulses afterwards, res_valid never asserts, op_count unchanged.
- op_count wrap:
  - Stimulus: preload op_count to 16'hFFFF via 65535 transactions or force, then complete one more transaction.
  - Required: op_count=0.
